easyaxi_slv_wr_ctrl: RTL

AXI write-channel slave controller: accepts AW requests into a parametrised outstanding FIFO and consumes W beats for the head request. It generates per-beat local write strobes with INCR/FIXED/WRAP address sequencing and returns a B response per burst. It sits beside the slave read controller in the top, replacing the constant-1 awready/wready ties on the master write controller.

---
 rtl/easyaxi_slv_wr_ctrl_pkg.sv | 34 +++
 rtl/easyaxi_sync_fifo.sv | 61 ++++++
 rtl/easyaxi_slv_wr_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/easyaxi_slv_wr_ctrl_pkg.sv
// Shared widths, AXI encodings and FSM states for the slave write controller.
package easyaxi_slv_wr_ctrl_pkg;

  localparam int AXI_ID_W    = 4;
  localparam int AXI_ADDR_W  = 32;
  localparam int AXI_DATA_W  = 32;
  localparam int AXI_LEN_W   = 8;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;
  localparam int AXI_RESP_W  = 2;
  localparam int AXI_USER_W  = 1;

  typedef enum logic [AXI_BURST_W-1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_e;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } wr_state_e;

  // WRAP bursts are only legal with 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_legal(input int unsigned len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

endpackage

// File: rtl/easyaxi_sync_fifo.sv
// Single-clock FIFO holding accepted AW requests; head is valid while not empty.
module easyaxi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count only, so a same-cycle pop never frees a slot.
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/easyaxi_slv_wr_ctrl.sv
// AXI write slave: queues AW requests, sequences W beats of the head burst into
// local write strobes and returns one B response per burst in acceptance order.
module easyaxi_slv_wr_ctrl
  import easyaxi_slv_wr_ctrl_pkg::*;
#(
  parameter int ID_W      = AXI_ID_W,
  parameter int ADDR_W    = AXI_ADDR_W,
  parameter int DATA_W    = AXI_DATA_W,
  parameter int LEN_W     = AXI_LEN_W,
  parameter int USER_W    = AXI_USER_W,
  parameter int OST_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                axi_slv_awvalid,
  output logic                axi_slv_awready,
  input  logic [ID_W-1:0]     axi_slv_awid,
  input  logic [ADDR_W-1:0]   axi_slv_awaddr,
  input  logic [LEN_W-1:0]    axi_slv_awlen,
  input  logic [2:0]          axi_slv_awsize,
  input  logic [1:0]          axi_slv_awburst,
  input  logic [USER_W-1:0]   axi_slv_awuser,
  input  logic                axi_slv_wvalid,
  output logic                axi_slv_wready,
  input  logic [DATA_W-1:0]   axi_slv_wdata,
  input  logic [DATA_W/8-1:0] axi_slv_wstrb,
  input  logic                axi_slv_wlast,
  input  logic [USER_W-1:0]   axi_slv_wuser,
  output logic                axi_slv_bvalid,
  input  logic                axi_slv_bready,
  output logic [ID_W-1:0]     axi_slv_bid,
  output logic [1:0]          axi_slv_bresp,
  output logic [USER_W-1:0]   axi_slv_buser,
  output logic                mem_wr_en,
  output logic [ADDR_W-1:0]   mem_wr_addr,
  output logic [DATA_W-1:0]   mem_wr_data,
  output logic [DATA_W/8-1:0] mem_wr_strb
);

  localparam int ENT_W    = ID_W + ADDR_W + LEN_W + 3 + 2 + USER_W;
  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  logic              fifo_full, fifo_empty;
  logic              aw_hs, w_hs, b_hs;
  logic [ENT_W-1:0]  head;
  logic [ID_W-1:0]   hd_id;
  logic [ADDR_W-1:0] hd_addr;
  logic [LEN_W-1:0]  hd_len;
  logic [2:0]        hd_size;
  logic [1:0]        hd_burst;
  logic [USER_W-1:0] hd_user;
  logic              hd_dec_err;
  logic              last_beat;
  logic              unused_bits;

  wr_state_e         state_q;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  beat_cnt_q;
  logic              err_q, err_d;
  logic              dec_err_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [ID_W-1:0]   bid_q;
  logic [1:0]        bresp_q;

  function automatic logic [ADDR_W-1:0] next_addr(
    input logic [ADDR_W-1:0] addr,
    input logic [LEN_W-1:0]  len,
    input logic [2:0]        size,
    input logic [1:0]        burst
  );
    logic [ADDR_W-1:0] bytes, total, lo, inc;
    bytes = ADDR_W'(1) << size;
    total = (ADDR_W'(len) + ADDR_W'(1)) << size;
    lo    = addr & ~(total - ADDR_W'(1));
    inc   = addr + bytes;
    case (burst)
      BURST_INCR: next_addr = inc;
      BURST_WRAP: next_addr = (inc == lo + total) ? lo : inc;
      default:    next_addr = addr;
    endcase
  endfunction

  assign aw_hs = axi_slv_awvalid && !fifo_full;
  assign w_hs  = axi_slv_wvalid && wready_q;
  assign b_hs  = bvalid_q && axi_slv_bready;

  easyaxi_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (OST_DEPTH)
  ) u_aw_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (aw_hs),
    .push_data_i ({axi_slv_awid, axi_slv_awaddr, axi_slv_awlen,
                   axi_slv_awsize, axi_slv_awburst, axi_slv_awuser}),
    .pop_i       (b_hs),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  assign {hd_id, hd_addr, hd_len, hd_size, hd_burst, hd_user} = head;

  assign hd_dec_err = (hd_burst == BURST_RSVD) ||
                      (hd_size > 3'(MAX_SIZE)) ||
                      ((hd_burst == BURST_WRAP) && !wrap_len_legal(32'(hd_len)));

  // The burst length is fixed by awlen; a misplaced wlast only flags the response.
  assign last_beat = (beat_cnt_q == hd_len);
  assign err_d     = err_q || (axi_slv_wlast != last_beat);
  assign addr_d    = next_addr(addr_q, hd_len, hd_size, hd_burst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      dec_err_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            addr_q     <= hd_addr;
            beat_cnt_q <= '0;
            err_q      <= hd_dec_err;
            dec_err_q  <= hd_dec_err;
            wready_q   <= 1'b1;
            state_q    <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (w_hs) begin
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_q + LEN_W'(1);
            err_q      <= err_d;
            if (last_beat) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bid_q    <= hd_id;
              bresp_q  <= err_d ? RESP_SLVERR : RESP_OKAY;
              state_q  <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          if (axi_slv_bready) begin
            bvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axi_slv_awready = !fifo_full;
  assign axi_slv_wready  = wready_q;
  assign axi_slv_bvalid  = bvalid_q;
  assign axi_slv_bid     = bid_q;
  assign axi_slv_bresp   = bresp_q;
  assign axi_slv_buser   = '0;

  // Decode errors swallow the beats; wlast errors still write.
  assign mem_wr_en   = w_hs && !dec_err_q;
  assign mem_wr_addr = addr_q;
  assign mem_wr_data = axi_slv_wdata;
  assign mem_wr_strb = axi_slv_wstrb;

  assign unused_bits = ^{axi_slv_wuser, hd_user};

endmodule
